val_seg_disp: RTL and testbench

- Display-side consumer of the 16-bit binary counter value `VAL` produced by the stopwatch counter.
- Converts `VAL` to decimal with an iterative shift-add-3 (double-dabble) converter.
- Drives a 4-digit multiplexed 7-segment display; segments and anodes are active-low.
- Values above 9999 show an overflow pattern instead of digits.

---
 rtl/val_seg_disp.sv | 172 +++++++++++++++++
 tb/tb_val_seg_disp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/val_seg_disp.sv
// 16-bit binary value to 4-digit multiplexed 7-segment display, using an iterative double-dabble converter.
// Optional macro LZ_BLANK_EN blanks leading-zero digits (ones digit always shown, no blanking on overflow).
module val_seg_disp #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VAL,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic [15:0] BCD,
  output logic        OVF,
  output logic        BUSY
);

  localparam int unsigned VW = 16;
  localparam int unsigned AW = 20;
  localparam int unsigned BCW = 5;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [VW-1:0]   shift_r;
  logic [VW-1:0]   last_r;
  logic [AW-1:0]   acc;
  logic [BCW-1:0]  bitcnt;
  logic            first;
  logic            load_c, shift_c, commit_c;
  logic [15:0]     acc_adj_c;

  logic [CW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic [3:0]      digit_c;
  logic            blank_c;
  logic [6:0]      seg_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Add-3 correction; the top nibble peaks at 3 before the final shift, so it never needs adjusting
  always_comb begin
    acc_adj_c = acc[15:0];
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Converter state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Converter next-state and control strobes
  always_comb begin
    state_n  = state;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    case (state)
      IDLE: begin
        if ((VAL != last_r) || first) begin
          load_c  = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        shift_c = 1'b1;
        if (bitcnt == BCW'(VW - 1)) state_n = COMMIT;
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Converter datapath and committed outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_r <= '0;
      last_r  <= '0;
      acc     <= '0;
      bitcnt  <= '0;
      first   <= 1'b1;
      BCD     <= '0;
      OVF     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      BUSY <= (state_n != IDLE);
      if (load_c) begin
        shift_r <= VAL;
        last_r  <= VAL;
        acc     <= '0;
        bitcnt  <= '0;
        first   <= 1'b0;
      end
      if (shift_c) begin
        acc     <= {acc[18:16], acc_adj_c, shift_r[VW-1]};
        shift_r <= {shift_r[VW-2:0], 1'b0};
        bitcnt  <= bitcnt + BCW'(1);
      end
      if (commit_c) begin
        BCD <= acc[15:0];
        OVF <= (acc[AW-1:16] != 4'd0);
      end
    end
  end

  // Digit select, leading-zero blanking and segment decode for the current scan index
  always_comb begin
    digit_c = BCD[3:0];
    blank_c = 1'b0;
    case (idx)
      2'd0:    digit_c = BCD[3:0];
      2'd1:    digit_c = BCD[7:4];
      2'd2:    digit_c = BCD[11:8];
      2'd3:    digit_c = BCD[15:12];
      default: digit_c = BCD[3:0];
    endcase
`ifdef LZ_BLANK_EN
    case (idx)
      2'd1:    blank_c = (BCD[15:4] == 12'd0);
      2'd2:    blank_c = (BCD[15:8] == 8'd0);
      2'd3:    blank_c = (BCD[15:12] == 4'd0);
      default: blank_c = 1'b0;
    endcase
`endif
    if (OVF)          seg_c = 7'b0111111;
    else if (blank_c) seg_c = 7'b1111111;
    else              seg_c = seg_decode(digit_c);
  end

  // Scan timer, digit index and registered display drive
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      idx      <= '0;
      SEG      <= 7'b1111111;
      AN       <= 4'b1111;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      AN  <= ~(4'b0001 << idx);
      SEG <= seg_c;
    end
  end

endmodule

// File: tb/tb_val_seg_disp.sv
// Self-checking bench for val_seg_disp: randomized and directed values against a decimal reference model.
module tb_val_seg_disp;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] VAL = 16'd0;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic [15:0] BCD;
  logic        OVF;
  logic        BUSY;

  int tests_run = 0;
  int tests_failed = 0;
  int unsigned last_val = 0;

  val_seg_disp #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .RST(RST), .VAL(VAL), .SEG(SEG), .AN(AN),
    .BCD(BCD), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] exp_bcd(input int unsigned v);
    int unsigned m;
    m = v % 10000;
    return 16'(((m / 1000) << 12) | (((m / 100) % 10) << 8) | (((m / 10) % 10) << 4) | (m % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned v, input int d);
    int unsigned pw;
    pw = 1;
    for (int k = 0; k < d; k++) pw = pw * 10;
    if (v > 9999) return 7'b0111111;
`ifdef LZ_BLANK_EN
    if (d > 0 && v < pw) return 7'b1111111;
`endif
    return SEG_TBL[(v / pw) % 10];
  endfunction

  // Waits for the converter to go busy and then settle idle; reports what it saw
  task automatic wait_conversion(output int busy_cycles, output bit timeout,
                                 output bit nonbcd, output bit partial);
    bit seen_busy;
    int low_run;
    logic [15:0] prev_bcd;
    busy_cycles = 0; timeout = 1'b1; nonbcd = 1'b0; partial = 1'b0;
    seen_busy = 1'b0; low_run = 0; prev_bcd = BCD;
    for (int c = 0; c < 120; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) if (BCD[4*i +: 4] > 4'd9) nonbcd = 1'b1;
      if (BUSY && BCD !== prev_bcd) partial = 1'b1;
      prev_bcd = BCD;
      if (BUSY) begin
        busy_cycles++; seen_busy = 1'b1; low_run = 0;
      end else begin
        low_run++;
      end
      if (seen_busy && low_run >= 2) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_display(input string name);
    logic [3:0] prev_an;
    int idx, prev_idx, run_len;
    bit seen_change;
    prev_an = AN; prev_idx = -1; run_len = 0; seen_change = 1'b0;
    for (int c = 0; c < 12 * SCAN_DIV; c++) begin
      @(negedge CLK);
      case (AN)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      tests_run++;
      if (idx < 0) begin
        tests_failed++;
        $display("FAIL %s an_onehot: AN=%b not one-hot low", name, AN);
        continue;
      end
      tests_run++;
      if (SEG !== exp_seg(last_val, idx)) begin
        tests_failed++;
        $display("FAIL %s seg digit %0d: SEG=%b expected %b (val %0d)", name, idx, SEG,
                 exp_seg(last_val, idx), last_val);
      end
      if (AN !== prev_an) begin
        if (seen_change) begin
          tests_run++;
          if (run_len != SCAN_DIV) begin
            tests_failed++;
            $display("FAIL %s dwell: digit lit %0d cycles expected %0d", name, run_len, SCAN_DIV);
          end
          tests_run++;
          if (idx != (prev_idx + 1) % 4) begin
            tests_failed++;
            $display("FAIL %s scan order: digit %0d after %0d", name, idx, prev_idx);
          end
        end
        seen_change = 1'b1;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_an = AN;
      prev_idx = idx;
    end
  endtask

  task automatic convert_and_check(input logic [15:0] v, input string name);
    int bc; bit to, nb, pt;
    @(negedge CLK);
    VAL = v;
    wait_conversion(bc, to, nb, pt);
    last_val = v;
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL %s timeout: converter never settled", name); end
    tests_run++;
    if (bc != 17) begin tests_failed++; $display("FAIL %s busy: %0d cycles expected 17", name, bc); end
    tests_run++;
    if (BCD !== exp_bcd(v)) begin tests_failed++; $display("FAIL %s bcd: %h expected %h", name, BCD, exp_bcd(v)); end
    tests_run++;
    if (OVF !== (v > 16'd9999)) begin tests_failed++; $display("FAIL %s ovf: %b expected %b", name, OVF, v > 16'd9999); end
    tests_run++;
    if (nb || pt) begin tests_failed++; $display("FAIL %s glitch: nonbcd=%b partial=%b expected 0 0", name, nb, pt); end
  endtask

  task automatic test_reset();
    int bc; bit to, nb, pt;
    VAL = 16'd0;
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (SEG !== 7'b1111111) begin tests_failed++; $display("FAIL reset seg: %b expected 1111111", SEG); end
    tests_run++;
    if (AN !== 4'b1111) begin tests_failed++; $display("FAIL reset an: %b expected 1111", AN); end
    tests_run++;
    if (BCD !== 16'h0000) begin tests_failed++; $display("FAIL reset bcd: %h expected 0000", BCD); end
    tests_run++;
    if (OVF !== 1'b0) begin tests_failed++; $display("FAIL reset ovf: %b expected 0", OVF); end
    tests_run++;
    if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset busy: %b expected 0", BUSY); end
    RST = 1'b0;
    last_val = 0;
    wait_conversion(bc, to, nb, pt);
    tests_run++;
    if (to || bc != 17) begin tests_failed++; $display("FAIL reset first conv: busy %0d timeout %b expected 17 0", bc, to); end
    tests_run++;
    if (BCD !== 16'h0000 || OVF !== 1'b0) begin tests_failed++; $display("FAIL reset first bcd: %h/%b expected 0000/0", BCD, OVF); end
    test_display("reset_zero");
  endtask

  task automatic test_directed();
    logic [15:0] vals [8] = '{16'd1234, 16'd9999, 16'd10000, 16'd65535, 16'd42, 16'd0, 16'd100, 16'd9};
    for (int i = 0; i < 8; i++) begin
      convert_and_check(vals[i], $sformatf("directed_%0d", vals[i]));
      test_display($sformatf("display_%0d", vals[i]));
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 10; i++) begin
      if ($urandom % 2 == 0) v = 16'($urandom_range(0, 9999));
      else                   v = 16'($urandom_range(0, 65535));
      if (32'(v) == last_val) v = v ^ 16'd1;
      convert_and_check(v, $sformatf("random_%0d", v));
      if (i % 3 == 0) test_display($sformatf("rdisplay_%0d", v));
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit to, nb, pt;
    convert_and_check(16'd8000, "b2b_setup");
    @(negedge CLK); VAL = 16'd5;
    repeat (3) @(negedge CLK); VAL = 16'd6;
    repeat (3) @(negedge CLK); VAL = 16'd7;
    wait_conversion(bc, to, nb, pt);
    last_val = 7;
    tests_run++;
    if (to || bc > 34) begin tests_failed++; $display("FAIL b2b settle: busy %0d timeout %b expected <=34 0", bc, to); end
    tests_run++;
    if (BCD !== 16'h0007 || OVF !== 1'b0) begin tests_failed++; $display("FAIL b2b bcd: %h/%b expected 0007/0", BCD, OVF); end
    tests_run++;
    if (nb || pt) begin tests_failed++; $display("FAIL b2b glitch: nonbcd=%b partial=%b expected 0 0", nb, pt); end
    test_display("b2b_display");
  endtask

  task automatic test_reset_mid();
    int bc; bit to, nb, pt;
    @(negedge CLK); VAL = 16'd4321;
    repeat (9) @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL rstmid busy before: %b expected 1", BUSY); end
    #2 RST = 1'b1;
    #1;
    tests_run++;
    if (SEG !== 7'b1111111 || AN !== 4'b1111) begin tests_failed++; $display("FAIL rstmid display: SEG=%b AN=%b expected 1111111 1111", SEG, AN); end
    tests_run++;
    if (BCD !== 16'h0000 || OVF !== 1'b0 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL rstmid state: BCD=%h OVF=%b BUSY=%b expected 0000 0 0", BCD, OVF, BUSY); end
    @(negedge CLK); RST = 1'b0;
    wait_conversion(bc, to, nb, pt);
    last_val = 4321;
    tests_run++;
    if (to || bc != 17) begin tests_failed++; $display("FAIL rstmid reconv: busy %0d timeout %b expected 17 0", bc, to); end
    tests_run++;
    if (BCD !== 16'h4321 || OVF !== 1'b0) begin tests_failed++; $display("FAIL rstmid bcd: %h/%b expected 4321/0", BCD, OVF); end
    test_display("rstmid_display");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
